// File: rtl/saph_plr_sched.sv
// saph_plr_sched: valid/ready wrapper around a fixed-latency, non-stallable
// datapath. Issue strobes go out on pipe_en, a token shift register follows
// each item through the datapath, and results land in an output FIFO that is
// re-presented as a valid/ready stream. Credits (inflight + fill) keep the FIFO
// from overflowing, because the datapath itself can never be held.
module saph_plr_sched #(
  parameter int width   = 1,
  parameter int latency = 1,
  parameter int depth   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [width-1:0]             in_data,
  output logic                         pipe_en,
  output logic [width-1:0]             pipe_d,
  input  logic [width-1:0]             pipe_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [width-1:0]             out_data,
  output logic [$clog2(depth+1)-1:0]   inflight,
  output logic [$clog2(depth+1)-1:0]   fill
);

  localparam int cw = $clog2(depth + 1);
  localparam int pw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [cw:0]   creditLimit = (cw + 1)'(depth);
  localparam logic [pw-1:0] lastSlot    = pw'(depth - 1);
  localparam bit            hasPipe     = (latency != 0);

  logic              issue;
  logic              arrive;
  logic              capture;
  logic              pop;
  logic              tokenIn;
  logic              tokenOut;
  logic [cw:0]       committed;
  logic [width-1:0]  mem [depth];
  logic [pw-1:0]     wptr;
  logic [pw-1:0]     rptr;

  // Credits come from registered counts only, so out_ready never reaches
  // in_ready combinationally; the extra sum bit rules out overflow.
  assign committed = {1'b0, inflight} + {1'b0, fill};
  assign in_ready  = ~flush & (committed < creditLimit);
  // Nothing may issue while reset is held, even though in_ready reads 1.
  assign issue     = in_valid & in_ready & rst;
  assign pipe_en   = issue;
  assign pipe_d    = in_data;
  assign capture   = arrive & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_valid = (fill != '0);
  assign out_data  = mem[rptr];

  // A combinational datapath has no tokens in flight: inflight stays at 0.
  assign tokenIn  = issue & hasPipe;
  assign tokenOut = arrive & hasPipe;

  generate
    if (latency == 0) begin : gComb
      assign arrive = issue;
    end else begin : gPipe
      logic [latency-1:0] vld;

      // Token shift register marching in step with the datapath registers.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld <= '0;
        end else if (flush) begin
          vld <= '0;
        end else begin
          vld[0] <= issue;
          for (int i = 1; i < latency; i++) begin
            vld[i] <= vld[i-1];
          end
        end
      end

      assign arrive = vld[latency-1];
    end
  endgenerate

  // In-flight token count: issue and arrival in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else if (tokenIn & ~tokenOut) begin
      inflight <= inflight + 1'b1;
    end else if (~tokenIn & tokenOut) begin
      inflight <= inflight - 1'b1;
    end
  end

  // FIFO occupancy: capture and pop in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill <= '0;
    end else if (flush) begin
      fill <= '0;
    end else if (capture & ~pop) begin
      fill <= fill + 1'b1;
    end else if (~capture & pop) begin
      fill <= fill - 1'b1;
    end
  end

  // FIFO storage and pointers; pointers wrap at depth so any depth works.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (capture) begin
        mem[wptr] <= pipe_q;
        wptr      <= (wptr == lastSlot) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == lastSlot) ? '0 : rptr + 1'b1;
      end
    end
  end

  // Credit accounting must keep both counters inside their physical range.
  always @(posedge clk) begin
    if (rst) begin
      assert (int'(fill) <= depth);
      assert (int'(inflight) <= latency);
    end
  end

endmodule
